// File: rtl/seq_det.sv
// Serial pattern detector fed by the upstream DFF stage's registered Q.
// Flags each occurrence of PATTERN in the accepted bit stream and keeps a
// saturating match count with a sticky saturation flag.
//
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - asynchronous active-high reset
//   en_i    - din_i valid this cycle; state holds when low (clr_i still acts)
//   din_i   - serial data bit
//   clr_i   - synchronous clear of history, fill, count and sat_o (beats en_i)
//   match_o - one-cycle pulse after the edge that sampled the final pattern bit
//   cnt_o   - saturating match count since reset/clear
//   sat_o   - sticky: a match arrived while cnt_o was already all-ones
//   hist_o  - last PAT_W accepted bits, newest in bit 0
module seq_det #(
   parameter int unsigned         PAT_W   = 4,
   parameter logic [PAT_W-1:0]    PATTERN = PAT_W'(4'b1101),
   parameter bit                  OVERLAP = 1'b1,
   parameter int unsigned         CNT_W   = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             din_i,
   input  logic             clr_i,
   output logic             match_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o,
   output logic [PAT_W-1:0] hist_o
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;
   logic              match_q, match_d;
   logic [PAT_W-1:0]  next_hist;
   logic              hit;

   // Candidate history and match qualifier; fill gating keeps the reset
   // zeros in the history from matching an all-zeros pattern.
   always_comb begin
      next_hist = {hist_q[PAT_W-2:0], din_i};
      hit       = (fill_q >= FILL_W'(PAT_W - 1)) && (next_hist == PATTERN);
   end

   // Next-state logic: clear beats enable; idle edges only drop the pulse.
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      match_d = 1'b0;
      if (clr_i) begin
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
         sat_d  = 1'b0;
      end else if (en_i) begin
         match_d = hit;
         if (hit && (OVERLAP == 1'b0)) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = next_hist;
            fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
         end
         if (hit) begin
            if (&cnt_q) begin
               sat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State registers; every output is taken straight from a flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         match_q <= match_d;
      end
   end

   assign match_o = match_q;
   assign cnt_o   = cnt_q;
   assign sat_o   = sat_q;
   assign hist_o  = hist_q;

endmodule

// File: tb/tb_seq_det.sv
// Directed bench for seq_det: four instances share the stimulus
//   u_a default (1101, overlap, 8-bit count)
//   u_b OVERLAP=0
//   u_c PATTERN=4'b0000
//   u_d CNT_W=2
module tb_seq_det;

   logic clk, rst, en, din, clr;
   logic       m_a, m_b, m_c, m_d;
   logic [7:0] c_a, c_b, c_c;
   logic [1:0] c_d;
   logic       s_a, s_b, s_c, s_d;
   logic [3:0] h_a, h_b, h_c, h_d;

   int checks = 0;
   int errors = 0;

   seq_det u_a (.clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din), .clr_i(clr),
                .match_o(m_a), .cnt_o(c_a), .sat_o(s_a), .hist_o(h_a));
   seq_det #(.OVERLAP(1'b0)) u_b (.clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din),
                .clr_i(clr), .match_o(m_b), .cnt_o(c_b), .sat_o(s_b), .hist_o(h_b));
   seq_det #(.PATTERN(4'b0000)) u_c (.clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din),
                .clr_i(clr), .match_o(m_c), .cnt_o(c_c), .sat_o(s_c), .hist_o(h_c));
   seq_det #(.CNT_W(2)) u_d (.clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din),
                .clr_i(clr), .match_o(m_d), .cnt_o(c_d), .sat_o(s_d), .hist_o(h_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, sample 1 ns after the rising edge.
   task automatic step(input logic e, input logic d, input logic c);
      @(negedge clk);
      en = e; din = d; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
      #2;
      checks++; if (m_a !== 1'b0) begin errors++; $display("FAIL reset_match got %0b exp 0", m_a); end
      checks++; if (c_a !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", c_a); end
      checks++; if (s_a !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b exp 0", s_a); end
      checks++; if (h_a !== 4'b0000) begin errors++; $display("FAIL reset_hist got %b exp 0000", h_a); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic bits [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, bits[i], 1'b0);
         checks++;
         if (m_a !== (i == 3)) begin
            errors++; $display("FAIL basic_match[%0d] got %0b exp %0b", i, m_a, (i == 3));
         end
      end
      checks++; if (c_a !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", c_a); end
      checks++; if (h_a !== 4'b1101) begin errors++; $display("FAIL basic_hist got %b exp 1101", h_a); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (m_a !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b exp 0", m_a); end
      checks++; if (h_a !== 4'b1101) begin errors++; $display("FAIL basic_hold got %b exp 1101", h_a); end
   endtask

   task automatic test_overlap();
      logic bits [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic exp_a [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic exp_b [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, bits[i], 1'b0);
         checks++;
         if (m_a !== exp_a[i]) begin
            errors++; $display("FAIL ovl_match[%0d] got %0b exp %0b", i, m_a, exp_a[i]);
         end
         checks++;
         if (m_b !== exp_b[i]) begin
            errors++; $display("FAIL noovl_match[%0d] got %0b exp %0b", i, m_b, exp_b[i]);
         end
      end
      checks++; if (c_a !== 8'd2) begin errors++; $display("FAIL ovl_cnt got %0d exp 2", c_a); end
      checks++; if (c_b !== 8'd1) begin errors++; $display("FAIL noovl_cnt got %0d exp 1", c_b); end
      checks++; if (h_b !== 4'b0101) begin errors++; $display("FAIL noovl_hist got %b exp 0101", h_b); end
   endtask

   task automatic test_enable_gap();
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0);
         checks++;
         if (m_a !== 1'b0) begin errors++; $display("FAIL gap_match[%0d] got %0b exp 0", i, m_a); end
         checks++;
         if (h_a !== 4'b0110) begin errors++; $display("FAIL gap_hist[%0d] got %b exp 0110", i, h_a); end
      end
      step(1'b1, 1'b1, 1'b0);
      checks++; if (m_a !== 1'b1) begin errors++; $display("FAIL gap_final_match got %0b exp 1", m_a); end
      checks++; if (c_a !== 8'd1) begin errors++; $display("FAIL gap_cnt got %0d exp 1", c_a); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      en = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (h_a !== 4'b0000) begin errors++; $display("FAIL midrst_hist got %b exp 0000", h_a); end
      #2 rst = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      checks++; if (m_a !== 1'b0) begin errors++; $display("FAIL midrst_match got %0b exp 0", m_a); end
      checks++; if (c_a !== 8'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", c_a); end
      checks++; if (h_a !== 4'b0001) begin errors++; $display("FAIL midrst_hist2 got %b exp 0001", h_a); end
   endtask

   task automatic test_zero_pattern();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (m_c !== (i == 3)) begin
            errors++; $display("FAIL zero_match[%0d] got %0b exp %0b", i, m_c, (i == 3));
         end
      end
      checks++; if (c_c !== 8'd1) begin errors++; $display("FAIL zero_cnt got %0d exp 1", c_c); end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      logic       exp_sat [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      // 1101 then 101 repeated: a new overlapping match every third bit
      for (int m = 0; m < 5; m++) begin
         step(1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         checks++;
         if (m_d !== 1'b1) begin errors++; $display("FAIL sat_match[%0d] got %0b exp 1", m, m_d); end
         checks++;
         if (c_d !== exp_cnt[m]) begin
            errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", m, c_d, exp_cnt[m]);
         end
         checks++;
         if (s_d !== exp_sat[m]) begin
            errors++; $display("FAIL sat_flag[%0d] got %0b exp %0b", m, s_d, exp_sat[m]);
         end
      end
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      checks++; if (m_d !== 1'b0) begin errors++; $display("FAIL sat_pre_clr got %0b exp 0", m_d); end
      // This bit would complete 1101, but clear wins.
      step(1'b1, 1'b1, 1'b1);
      checks++; if (m_d !== 1'b0) begin errors++; $display("FAIL clr_match got %0b exp 0", m_d); end
      checks++; if (c_d !== 2'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", c_d); end
      checks++; if (s_d !== 1'b0) begin errors++; $display("FAIL clr_sat got %0b exp 0", s_d); end
      checks++; if (h_d !== 4'b0000) begin errors++; $display("FAIL clr_hist got %b exp 0000", h_d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_enable_gap();
      test_mid_reset();
      test_zero_pattern();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
